// File: rtl/lc3b_types.sv
// Shared LC-3b memory-port types and the responder FSM state encoding.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } lc3b_memresp_state;

endpackage

// File: rtl/lc3b_mem_responder_if.sv
// CPU-to-memory request/response handshake bundle.
interface lc3b_mem_responder_if;
    import lc3b_types::*;

    logic          mem_read;
    logic          mem_write;
    lc3b_mem_wmask mem_byte_enable;
    lc3b_word      mem_address;
    lc3b_word      mem_wdata;
    logic          mem_resp;
    lc3b_word      mem_rdata;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata
    );

endinterface

// File: rtl/lc3b_byte_ram.sv
// Word RAM with a byte-lane write port (A), a full-word write port (B) and one
// registered read port. Port A lanes override port B on a same-word collision.
module lc3b_byte_ram
    import lc3b_types::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_a,
    input  lc3b_mem_wmask        mask_a,
    input  logic [ADDR_BITS-1:0] addr_a,
    input  lc3b_word             wdata_a,
    input  logic                 we_b,
    input  logic [ADDR_BITS-1:0] addr_b,
    input  lc3b_word             wdata_b,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output lc3b_word             rdata
);

    lc3b_word mem [2**ADDR_BITS];

    // Port B is written first so the later port A lane updates take priority.
    always_ff @(posedge clk) begin
        if (we_b) mem[addr_b] <= wdata_b;
        if (we_a && mask_a[0]) mem[addr_a][7:0]  <= wdata_a[7:0];
        if (we_a && mask_a[1]) mem[addr_a][15:8] <= wdata_a[15:8];
    end

    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/lc3b_mem_responder.sv
// Memory-side responder for the LC-3b memory port: fixed-latency read/write
// service with byte-lane writes, a backdoor init port and a sticky error flag.
module lc3b_mem_responder
    import lc3b_types::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    lc3b_mem_responder_if.slave      bus,
    input  logic                     init_we,
    input  logic [ADDR_BITS-1:0]     init_addr,
    input  lc3b_word                 init_data,
    output logic                     proto_err
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    lc3b_memresp_state    state_q, next_state;
    logic [3:0]           cnt_q;
    logic [ADDR_BITS-1:0] cap_idx;
    lc3b_word             cap_wdata;
    lc3b_mem_wmask        cap_mask;
    logic                 cap_write;
    logic                 resp_q;
    lc3b_word             rdata_q;
    lc3b_word             ram_q;
    logic                 accept, abort, req;
    logic [ADDR_BITS-1:0] live_idx;
    logic                 unused_addr;

    assign req         = bus.mem_read | bus.mem_write;
    assign live_idx    = bus.mem_address[ADDR_BITS:1];
    assign unused_addr = ^{bus.mem_address[15:ADDR_BITS+1], bus.mem_address[0]};

    always_comb begin
        next_state = state_q;
        accept     = 1'b0;
        abort      = 1'b0;
        case (state_q)
            IDLE: if (req) begin
                accept     = 1'b1;
                next_state = (LATENCY == 1) ? RESP : BUSY;
            end
            BUSY: if (!req) begin
                abort      = 1'b1;
                next_state = IDLE;
            end else if (cnt_q == 4'd1) begin
                next_state = RESP;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            resp_q    <= 1'b0;
            rdata_q   <= '0;
            proto_err <= 1'b0;
        end else begin
            state_q <= next_state;
            resp_q  <= (next_state == RESP);
            if (accept)                cnt_q <= LAT_M1;
            else if (state_q == BUSY)  cnt_q <= cnt_q - 4'd1;
            if ((accept && bus.mem_read && bus.mem_write) || abort) proto_err <= 1'b1;
            if (state_q == BUSY && next_state == RESP && !cap_write) rdata_q <= ram_q;
        end
    end

    // Transaction attributes are frozen at acceptance; later bus changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_idx   <= live_idx;
            cap_wdata <= bus.mem_wdata;
            cap_mask  <= bus.mem_byte_enable;
            cap_write <= bus.mem_write;
        end
    end

    // Reads sample the RAM at acceptance so a same-cycle init write is not seen.
    lc3b_byte_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_a    ((state_q == RESP) && cap_write && !rst),
        .mask_a  (cap_mask),
        .addr_a  (cap_idx),
        .wdata_a (cap_wdata),
        .we_b    (init_we),
        .addr_b  (init_addr),
        .wdata_b (init_data),
        .re      (accept && !bus.mem_write),
        .raddr   (live_idx),
        .rdata   (ram_q)
    );

    assign bus.mem_resp  = resp_q;
    assign bus.mem_rdata = (LATENCY == 1) ? ram_q : rdata_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Directed bench for lc3b_mem_responder with ADDR_BITS=8, LATENCY=3.
module tb_lc3b_mem_responder;
    import lc3b_types::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_we;
    logic [7:0] init_addr;
    lc3b_word   init_data;
    logic       proto_err;
    int         errors = 0;
    int         checks = 0;

    lc3b_mem_responder_if bus();

    lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic init_write(input logic [7:0] a, input lc3b_word d);
        @(posedge clk); #1;
        init_we = 1'b1; init_addr = a; init_data = d;
        @(posedge clk); #1;
        init_we = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Issue one request, hold it until mem_resp, then drop it.
    task automatic cpu_access(input logic rd, input logic wr, input lc3b_word addr,
                              input lc3b_word wd, input lc3b_mem_wmask mask,
                              output int lat, output lc3b_word rdata, output logic after);
        @(posedge clk); #1;
        bus.mem_read = rd; bus.mem_write = wr; bus.mem_address = addr;
        bus.mem_wdata = wd; bus.mem_byte_enable = mask;
        lat = -1; rdata = 'x;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.mem_resp) begin
                lat = n; rdata = bus.mem_rdata;
                break;
            end
        end
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        @(negedge clk);
        after = bus.mem_resp;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.mem_resp !== 1'b0) begin errors++; $display("FAIL reset_resp got=%b exp=0", bus.mem_resp); end
        checks++; if (bus.mem_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got=%h exp=0000", bus.mem_rdata); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", proto_err); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=IDLE", dut.state_q); end
    endtask

    task automatic test_read_latency();
        int lat; lc3b_word rd; logic aft;
        init_write(8'd5, 16'h1234);
        cpu_access(1'b1, 1'b0, 16'h000A, 16'h0, 2'b00, lat, rd, aft);
        checks++; if (lat !== 3) begin errors++; $display("FAIL read_latency got=%0d exp=3", lat); end
        checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL read_data got=%h exp=1234", rd); end
        checks++; if (aft !== 1'b0) begin errors++; $display("FAIL read_pulse_width got=%b exp=0", aft); end
    endtask

    task automatic test_byte_writes();
        int lat; lc3b_word rd; logic aft;
        init_write(8'h08, 16'h0000);
        cpu_access(1'b0, 1'b1, 16'h0010, 16'hABCD, 2'b10, lat, rd, aft);
        checks++; if (lat !== 3 || rd !== 16'h1234) begin errors++; $display("FAIL wr_hi_resp lat=%0d rdata=%h exp lat=3 rdata=1234", lat, rd); end
        cpu_access(1'b1, 1'b0, 16'h0010, 16'h0, 2'b00, lat, rd, aft);
        checks++; if (rd !== 16'hAB00) begin errors++; $display("FAIL wr_hi_data got=%h exp=AB00", rd); end
        cpu_access(1'b0, 1'b1, 16'h0010, 16'h00EF, 2'b01, lat, rd, aft);
        checks++; if (lat !== 3 || rd !== 16'hAB00) begin errors++; $display("FAIL wr_lo_resp lat=%0d rdata=%h exp lat=3 rdata=AB00", lat, rd); end
        cpu_access(1'b1, 1'b0, 16'h0010, 16'h0, 2'b00, lat, rd, aft);
        checks++; if (rd !== 16'hABEF) begin errors++; $display("FAIL wr_lo_data got=%h exp=ABEF", rd); end
        cpu_access(1'b0, 1'b1, 16'h0010, 16'hFFFF, 2'b00, lat, rd, aft);
        checks++; if (lat !== 3) begin errors++; $display("FAIL wr_mask0_lat got=%0d exp=3", lat); end
        cpu_access(1'b1, 1'b0, 16'h0010, 16'h0, 2'b00, lat, rd, aft);
        checks++; if (rd !== 16'hABEF) begin errors++; $display("FAIL wr_mask0_data got=%h exp=ABEF", rd); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int cyc[2];
        lc3b_word dat[2];
        init_write(8'd0, 16'h1111);
        init_write(8'd1, 16'h2222);
        @(posedge clk); #1;
        bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.mem_address = 16'h0000;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (bus.mem_resp) begin
                if (pulses < 2) begin cyc[pulses] = n; dat[pulses] = bus.mem_rdata; end
                pulses++;
                bus.mem_address = 16'h0002;
                if (pulses == 2) bus.mem_read = 1'b0;
            end
        end
        bus.mem_read = 1'b0;
        checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
        checks++; if (cyc[0] !== 3 || dat[0] !== 16'h1111) begin errors++; $display("FAIL b2b_first cyc=%0d data=%h exp cyc=3 data=1111", cyc[0], dat[0]); end
        checks++; if (cyc[1] !== 7 || dat[1] !== 16'h2222) begin errors++; $display("FAIL b2b_second cyc=%0d data=%h exp cyc=7 data=2222", cyc[1], dat[1]); end
    endtask

    task automatic test_alias();
        int lat; lc3b_word rd; logic aft;
        cpu_access(1'b0, 1'b1, 16'h0202, 16'hBEEF, 2'b11, lat, rd, aft);
        cpu_access(1'b1, 1'b0, 16'h0002, 16'h0, 2'b00, lat, rd, aft);
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL alias_high_bits got=%h exp=BEEF", rd); end
        cpu_access(1'b1, 1'b0, 16'h0003, 16'h0, 2'b00, lat, rd, aft);
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL alias_bit0 got=%h exp=BEEF", rd); end
    endtask

    task automatic test_proto_err();
        int lat; lc3b_word rd; logic aft;
        int seen;
        cpu_access(1'b1, 1'b1, 16'h0006, 16'hC0DE, 2'b11, lat, rd, aft);
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL both_high_err got=%b exp=1", proto_err); end
        cpu_access(1'b1, 1'b0, 16'h0006, 16'h0, 2'b00, lat, rd, aft);
        checks++; if (rd !== 16'hC0DE) begin errors++; $display("FAIL both_high_write got=%h exp=C0DE", rd); end
        pulse_reset();
        @(negedge clk);
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", proto_err); end
        @(posedge clk); #1;
        bus.mem_read = 1'b1; bus.mem_address = 16'h0006;
        @(posedge clk); #1;
        bus.mem_read = 1'b0;
        seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus.mem_resp) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL drop_no_resp got=%0d pulses exp=0", seen); end
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL drop_err_sticky got=%b exp=1", proto_err); end
        pulse_reset();
        @(negedge clk);
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL drop_err_clear got=%b exp=0", proto_err); end
    endtask

    task automatic test_reset_abort();
        int lat; lc3b_word rd; logic aft;
        int seen;
        init_write(8'd2, 16'h5555);
        @(posedge clk); #1;
        bus.mem_write = 1'b1; bus.mem_address = 16'h0004;
        bus.mem_wdata = 16'h0000; bus.mem_byte_enable = 2'b11;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.mem_write = 1'b0;
        seen = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (bus.mem_resp) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_resp got=%0d pulses exp=0", seen); end
        checks++; if (bus.mem_rdata !== 16'h0000) begin errors++; $display("FAIL abort_rdata got=%h exp=0000", bus.mem_rdata); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL abort_state got=%0d exp=IDLE", dut.state_q); end
        cpu_access(1'b1, 1'b0, 16'h0004, 16'h0, 2'b00, lat, rd, aft);
        checks++; if (rd !== 16'h5555) begin errors++; $display("FAIL abort_ram got=%h exp=5555", rd); end
    endtask

    initial begin
        rst = 1'b0; init_we = 1'b0; init_addr = '0; init_data = '0;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_address = '0;
        bus.mem_wdata = '0; bus.mem_byte_enable = '0;
        test_reset();
        test_read_latency();
        test_byte_writes();
        test_back_to_back();
        test_alias();
        test_proto_err();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
